// File: rtl/peripheral_msi_slave_port_qos_ahb3_pkg.sv
// Shared AHB3-Lite encodings and burst-length helper for the MSI slave-port arbiter.
package peripheral_msi_ahb3_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    // Wide enough to hold the remaining beats of a 16-beat burst.
    localparam int BEATS_W = 4;

    // Beats still to come after the NONSEQ of a burst; undefined-length INCR counts as single.
    function automatic logic [BEATS_W-1:0] burst_beats(input logic [2:0] hburst);
        logic [BEATS_W-1:0] remaining;
        case (hburst_e'(hburst))
            HBURST_WRAP4,  HBURST_INCR4:  remaining = 4'd3;
            HBURST_WRAP8,  HBURST_INCR8:  remaining = 4'd7;
            HBURST_WRAP16, HBURST_INCR16: remaining = 4'd15;
            default:                      remaining = 4'd0;
        endcase
        return remaining;
    endfunction

endpackage

// File: rtl/peripheral_msi_slave_port_qos_ahb3_if.sv
// Bus bundle between the MSI masters, the arbiter and the shared slave port.
interface peripheral_msi_slave_port_qos_ahb3_if #(
    parameter int PLEN    = 64,
    parameter int XLEN    = 64,
    parameter int MASTERS = 5
);
    // Master-side buses, one lane per requesting master.
    logic [MASTERS-1:0]           mstHSEL;
    logic [MASTERS-1:0][PLEN-1:0] mstHADDR;
    logic [MASTERS-1:0][XLEN-1:0] mstHWDATA;
    logic [MASTERS-1:0]           mstHWRITE;
    logic [MASTERS-1:0][2:0]      mstHSIZE;
    logic [MASTERS-1:0][2:0]      mstHBURST;
    logic [MASTERS-1:0][3:0]      mstHPROT;
    logic [MASTERS-1:0][1:0]      mstHTRANS;
    logic [MASTERS-1:0]           mstHMASTLOCK;
    logic [MASTERS-1:0]           mstHREADY;
    logic [XLEN-1:0]              mstHRDATA;
    logic [MASTERS-1:0]           mstHREADYOUT;
    logic [MASTERS-1:0]           mstHRESP;

    // Shared slave port.
    logic                         slv_HSEL;
    logic [PLEN-1:0]              slv_HADDR;
    logic [XLEN-1:0]              slv_HWDATA;
    logic                         slv_HWRITE;
    logic [2:0]                   slv_HSIZE;
    logic [2:0]                   slv_HBURST;
    logic [3:0]                   slv_HPROT;
    logic [1:0]                   slv_HTRANS;
    logic                         slv_HMASTLOCK;
    logic                         slv_HREADYOUT;
    logic [XLEN-1:0]              slv_HRDATA;
    logic                         slv_HREADY;
    logic                         slv_HRESP;

    // The arbiter is the slave seen by the masters and drives the slave port.
    modport slave (
        input  mstHSEL, mstHADDR, mstHWDATA, mstHWRITE, mstHSIZE, mstHBURST,
               mstHPROT, mstHTRANS, mstHMASTLOCK, mstHREADY,
        output mstHRDATA, mstHREADYOUT, mstHRESP,
        output slv_HSEL, slv_HADDR, slv_HWDATA, slv_HWRITE, slv_HSIZE, slv_HBURST,
               slv_HPROT, slv_HTRANS, slv_HMASTLOCK, slv_HREADYOUT,
        input  slv_HRDATA, slv_HREADY, slv_HRESP
    );

    // Environment view: masters drive requests, the slave drives responses.
    modport master (
        output mstHSEL, mstHADDR, mstHWDATA, mstHWRITE, mstHSIZE, mstHBURST,
               mstHPROT, mstHTRANS, mstHMASTLOCK, mstHREADY,
        input  mstHRDATA, mstHREADYOUT, mstHRESP,
        input  slv_HSEL, slv_HADDR, slv_HWDATA, slv_HWRITE, slv_HSIZE, slv_HBURST,
               slv_HPROT, slv_HTRANS, slv_HMASTLOCK, slv_HREADYOUT,
        output slv_HRDATA, slv_HREADY, slv_HRESP
    );
endinterface

// File: rtl/peripheral_msi_slave_port_qos_ahb3_rr_arbiter.sv
// Priority pick with per-level round-robin: highest effective level wins, ties rotate
// starting just after the master last granted at that level.
module peripheral_msi_rr_arbiter #(
    parameter int MASTERS   = 5,
    parameter int PRIO_BITS = 3,
    localparam int IDX_W    = $clog2(MASTERS),
    localparam int LEVELS   = 2 ** PRIO_BITS
)(
    input  logic [MASTERS-1:0]                req,
    input  logic [MASTERS-1:0][PRIO_BITS-1:0] eff_prio,
    input  logic [LEVELS-1:0][IDX_W-1:0]      last_granted,
    output logic [MASTERS-1:0]                pick_oh,
    output logic [IDX_W-1:0]                  pick_idx,
    output logic [PRIO_BITS-1:0]              pick_level,
    output logic                              pick_valid
);

    // Find the top requesting level, then rotate through that level from last_granted+1.
    always_comb begin
        int  c;
        logic found;
        // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latch).
        pick_level = '0;
        pick_valid = 1'b0;
        pick_idx   = '0;
        pick_oh    = '0;
        found      = 1'b0;
        c          = 0;
        for (int m = 0; m < MASTERS; m++) begin
            if (req[m] && (!pick_valid || eff_prio[m] > pick_level)) begin
                pick_level = eff_prio[m];
                pick_valid = 1'b1;
            end
        end
        for (int k = 1; k <= MASTERS; k++) begin
            c = int'(last_granted[pick_level]) + k;
            if (c >= MASTERS) c = c - MASTERS;
            if (!found && req[c] && eff_prio[c] == pick_level) begin
                found    = 1'b1;
                pick_idx = IDX_W'(c);
            end
        end
        if (pick_valid) pick_oh[pick_idx] = 1'b1;
    end

endmodule

// File: rtl/peripheral_msi_slave_port_qos_ahb3.sv
// AHB3-Lite slave-port arbiter: MASTERS masters share one slave with priority,
// round-robin, burst/lock-safe switching, starvation aging and SEQ->NONSEQ fix-up.
module peripheral_msi_slave_port_qos_ahb3
    import peripheral_msi_ahb3_pkg::*;
#(
    parameter int PLEN         = 64,
    parameter int XLEN         = 64,
    parameter int MASTERS      = 5,
    parameter int PRIO_BITS    = 3,
    parameter int AGE_BITS     = 4,
    parameter int STARVE_LIMIT = 12
)(
    input  logic                              HCLK,
    input  logic                              HRESETn,
    input  logic [MASTERS-1:0][PRIO_BITS-1:0] mstpriority,
    peripheral_msi_slave_port_qos_ahb3_if.slave bus,
    output logic [MASTERS-1:0]                granted_master
);

    localparam int IDX_W  = $clog2(MASTERS);
    localparam int LEVELS = 2 ** PRIO_BITS;
    localparam logic [AGE_BITS-1:0] AGE_MAX = AGE_BITS'(STARVE_LIMIT);

    logic [IDX_W-1:0]                  g_idx;
    logic [IDX_W-1:0]                  owner_idx;
    logic [LEVELS-1:0][IDX_W-1:0]      last_granted;
    logic [MASTERS-1:0][AGE_BITS-1:0]  age;
    logic [BEATS_W-1:0]                beats_left;
    logic                              fixup;

    logic [MASTERS-1:0]                req;
    logic [MASTERS-1:0][PRIO_BITS-1:0] eff_prio;
    logic [MASTERS-1:0]                pick_oh;
    logic [IDX_W-1:0]                  pick_idx;
    logic [PRIO_BITS-1:0]              pick_level;
    logic                              pick_valid;

    htrans_e                           htrans_g;
    logic                              sel_g;
    logic                              lock_g;
    logic [2:0]                        hburst_g;
    logic [PLEN-1:0]                   haddr_g;
    logic [XLEN-1:0]                   hwdata_owner;
    logic                              switch_ok;
    logic                              take_grant;

    // Requests, aged priorities and the granted master's control fields.
    always_comb begin
        for (int m = 0; m < MASTERS; m++) begin
            req[m]      = bus.mstHSEL[m] & bus.mstHTRANS[m][1];
            eff_prio[m] = (age[m] == AGE_MAX) ? {PRIO_BITS{1'b1}} : mstpriority[m];
        end
        htrans_g   = htrans_e'(bus.mstHTRANS[g_idx]);
        sel_g      = bus.mstHSEL[g_idx];
        lock_g     = bus.mstHMASTLOCK[g_idx];
        hburst_g   = bus.mstHBURST[g_idx];
        // Never hand over during a lock, an unfinished burst, a BUSY or a SEQ beat.
        switch_ok  = bus.slv_HREADY & ~(sel_g & lock_g) & (beats_left == '0)
                   & (htrans_g != HTRANS_BUSY) & (htrans_g != HTRANS_SEQ);
        take_grant = switch_ok & pick_valid;
    end

    peripheral_msi_rr_arbiter #(
        .MASTERS   (MASTERS),
        .PRIO_BITS (PRIO_BITS)
    ) u_arb (
        .req          (req),
        .eff_prio     (eff_prio),
        .last_granted (last_granted),
        .pick_oh      (pick_oh),
        .pick_idx     (pick_idx),
        .pick_level   (pick_level),
        .pick_valid   (pick_valid)
    );

    // Address-phase grant and per-level round-robin pointers; last_granted of 0 means master 0.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            granted_master <= MASTERS'(1);
            g_idx          <= '0;
            // NOTE: the per-level pointer table is control state and is reset, unlike a data memory.
            last_granted   <= '0;
        end else if (take_grant) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            granted_master           <= pick_oh;
            g_idx                    <= pick_idx;
            last_granted[pick_level] <= pick_idx;
        end
    end

    // Data-phase owner follows the address-phase owner whenever the slave accepts.
    always_ff @(posedge HCLK) begin
        if (!HRESETn)             owner_idx <= '0;
        else if (bus.slv_HREADY) owner_idx <= g_idx;
    end

    // Remaining beats of the granted master's burst.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            beats_left <= '0;
        end else if (bus.slv_HREADY) begin
            if (htrans_g == HTRANS_NONSEQ)
                beats_left <= burst_beats(hburst_g);
            else if (htrans_g == HTRANS_SEQ && beats_left != '0)
                beats_left <= beats_left - 1'b1;
        end
    end

    // Starvation counters: count waiting cycles, saturate at the promotion threshold.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            age <= '0;
        end else begin
            for (int m = 0; m < MASTERS; m++) begin
                if (req[m] && !granted_master[m]) begin
                    if (age[m] != AGE_MAX) age[m] <= age[m] + 1'b1;
                end else begin
                    age[m] <= '0;
                end
            end
        end
    end

    // Fix-up flag marks the first address cycle of a newly granted master.
    always_ff @(posedge HCLK) begin
        if (!HRESETn)                           fixup <= 1'b0;
        else if (take_grant && pick_idx != g_idx) fixup <= 1'b1;
        else if (bus.slv_HREADY)                fixup <= 1'b0;
    end

    // Slave-port muxes plus per-master ready/response fan-out.
    always_comb begin
        haddr_g           = bus.mstHADDR[g_idx];
        hwdata_owner      = bus.mstHWDATA[owner_idx];
        bus.slv_HSEL      = sel_g;
        bus.slv_HADDR     = haddr_g;
        bus.slv_HWDATA    = hwdata_owner;
        bus.slv_HWRITE    = bus.mstHWRITE[g_idx];
        bus.slv_HSIZE     = bus.mstHSIZE[g_idx];
        bus.slv_HBURST    = hburst_g;
        bus.slv_HPROT     = bus.mstHPROT[g_idx];
        bus.slv_HMASTLOCK = lock_g;
        bus.slv_HREADYOUT = bus.mstHREADY[g_idx];
        bus.slv_HTRANS    = (fixup && htrans_g == HTRANS_SEQ) ? HTRANS_NONSEQ : htrans_g;
        bus.mstHRDATA     = bus.slv_HRDATA;
        for (int m = 0; m < MASTERS; m++) begin
            if (IDX_W'(m) == owner_idx || IDX_W'(m) == g_idx)
                bus.mstHREADYOUT[m] = bus.slv_HREADY;
            else
                bus.mstHREADYOUT[m] = ~req[m];
            bus.mstHRESP[m] = (IDX_W'(m) == owner_idx) ? bus.slv_HRESP : 1'b0;
        end
    end

endmodule

// File: tb/tb_peripheral_msi_slave_port_qos_ahb3.sv
// Self-checking bench: directed scenarios with literal expectations plus a randomized
// phase, all outputs compared every cycle against a behavioural arbitration model.
module tb_peripheral_msi_slave_port_qos_ahb3;
    import peripheral_msi_ahb3_pkg::*;

    localparam int PLEN = 64;
    localparam int XLEN = 64;
    localparam int M    = 5;
    localparam int PB   = 3;
    localparam int AB   = 4;
    localparam int SL   = 12;
    localparam int LV   = 8;

    logic                   HCLK = 1'b0;
    logic                   HRESETn;
    logic [M-1:0][PB-1:0]   mstpriority;
    logic [M-1:0]           granted_master;

    peripheral_msi_slave_port_qos_ahb3_if #(.PLEN(PLEN), .XLEN(XLEN), .MASTERS(M)) bus ();

    peripheral_msi_slave_port_qos_ahb3 #(
        .PLEN(PLEN), .XLEN(XLEN), .MASTERS(M), .PRIO_BITS(PB), .AGE_BITS(AB), .STARVE_LIMIT(SL)
    ) dut (
        .HCLK           (HCLK),
        .HRESETn        (HRESETn),
        .mstpriority    (mstpriority),
        .bus            (bus),
        .granted_master (granted_master)
    );

    always #5 HCLK = ~HCLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int m_g, m_owner, m_beats, m_age [M], m_last [LV];
    bit m_fix, m_valid = 1'b0;
    int n_g, n_owner, n_beats, n_age [M], n_last [LV];
    bit n_fix, n_valid;

    function automatic int burst_len(input logic [2:0] b);
        case (b)
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            3'd6, 3'd7: return 16;
            default:    return 1;
        endcase
    endfunction

    always @(negedge HCLK) begin : model_cmp
        int eff [M];
        bit rq [M];
        int top, win, c;
        bit sw;
        logic [1:0]   tg, e_trans;
        logic [M-1:0] e_gm, e_ro, e_rs;
        for (int m = 0; m < M; m++) begin
            rq[m]  = bus.mstHSEL[m] && bus.mstHTRANS[m][1];
            eff[m] = (m_age[m] == SL) ? LV - 1 : int'(mstpriority[m]);
        end
        top = -1;
        for (int m = 0; m < M; m++) if (rq[m] && eff[m] > top) top = eff[m];
        win = -1;
        if (top >= 0) begin
            for (int k = 1; k <= M; k++) begin
                c = (m_last[top] + k) % M;
                if (win < 0 && rq[c] && eff[c] == top) win = c;
            end
        end
        tg = bus.mstHTRANS[m_g];

        if (m_valid) begin
            e_gm = '0;
            e_gm[m_g] = 1'b1;
            for (int m = 0; m < M; m++) begin
                e_ro[m] = (m == m_owner || m == m_g) ? bus.slv_HREADY : !rq[m];
                e_rs[m] = (m == m_owner) ? bus.slv_HRESP : 1'b0;
            end
            e_trans = (m_fix && tg == 2'b11) ? 2'b10 : tg;
            check("granted_master", granted_master, e_gm);
            check("mstHREADYOUT", bus.mstHREADYOUT, e_ro);
            check("mstHRESP", bus.mstHRESP, e_rs);
            check("slv_HTRANS", bus.slv_HTRANS, e_trans);
            check("slv_HADDR", bus.slv_HADDR, bus.mstHADDR[m_g]);
            check("slv_HWDATA", bus.slv_HWDATA, bus.mstHWDATA[m_owner]);
            check("slv_ctrl",
                  {bus.slv_HSEL, bus.slv_HWRITE, bus.slv_HSIZE, bus.slv_HBURST, bus.slv_HPROT,
                   bus.slv_HMASTLOCK, bus.slv_HREADYOUT},
                  {bus.mstHSEL[m_g], bus.mstHWRITE[m_g], bus.mstHSIZE[m_g], bus.mstHBURST[m_g],
                   bus.mstHPROT[m_g], bus.mstHMASTLOCK[m_g], bus.mstHREADY[m_g]});
            check("mstHRDATA", bus.mstHRDATA, bus.slv_HRDATA);
        end

        n_g = m_g; n_owner = m_owner; n_beats = m_beats; n_fix = m_fix; n_valid = m_valid;
        n_age = m_age; n_last = m_last;
        if (HRESETn !== 1'b1) begin
            n_g = 0; n_owner = 0; n_beats = 0; n_fix = 1'b0; n_valid = 1'b1;
            for (int m = 0; m < M; m++) n_age[m] = 0;
            for (int l = 0; l < LV; l++) n_last[l] = 0;
        end else if (m_valid) begin
            sw = bus.slv_HREADY && !(bus.mstHSEL[m_g] && bus.mstHMASTLOCK[m_g])
                 && m_beats == 0 && tg != 2'b01 && tg != 2'b11;
            if (sw && win >= 0) begin
                n_g = win;
                n_last[top] = win;
                n_fix = (win != m_g);
            end else if (bus.slv_HREADY) begin
                n_fix = 1'b0;
            end
            if (bus.slv_HREADY) begin
                n_owner = m_g;
                if (tg == 2'b10) n_beats = burst_len(bus.mstHBURST[m_g]) - 1;
                else if (tg == 2'b11 && m_beats > 0) n_beats = m_beats - 1;
            end
            for (int m = 0; m < M; m++)
                n_age[m] = (rq[m] && m != m_g) ? ((m_age[m] < SL) ? m_age[m] + 1 : SL) : 0;
        end
    end

    always @(posedge HCLK) begin
        m_g     <= n_g;
        m_owner <= n_owner;
        m_beats <= n_beats;
        m_fix   <= n_fix;
        m_valid <= n_valid;
        m_age   <= n_age;
        m_last  <= n_last;
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic release_m(input int m);
        bus.mstHSEL[m]      = 1'b0;
        bus.mstHTRANS[m]    = 2'b00;
        bus.mstHMASTLOCK[m] = 1'b0;
        bus.mstHBURST[m]    = 3'd0;
    endtask

    task automatic drive(input int m, input logic [1:0] tr, input logic [2:0] bu, input logic lk);
        bus.mstHSEL[m]      = 1'b1;
        bus.mstHTRANS[m]    = tr;
        bus.mstHBURST[m]    = bu;
        bus.mstHMASTLOCK[m] = lk;
        bus.mstHADDR[m]     = {$urandom, $urandom};
        bus.mstHWDATA[m]    = {$urandom, $urandom};
        bus.mstHWRITE[m]    = 1'($urandom);
        bus.mstHSIZE[m]     = 3'($urandom);
        bus.mstHPROT[m]     = 4'($urandom);
    endtask

    task automatic idle_all();
        for (int m = 0; m < M; m++) begin
            release_m(m);
            bus.mstHADDR[m]  = '0;
            bus.mstHWDATA[m] = '0;
            bus.mstHWRITE[m] = 1'b0;
            bus.mstHSIZE[m]  = 3'd0;
            bus.mstHPROT[m]  = 4'd0;
        end
        mstpriority = '0;
    endtask

    task automatic do_reset();
        idle_all();
        HRESETn = 1'b0;
        step();
        HRESETn = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    initial begin
        HRESETn = 1'b0;
        idle_all();
        bus.mstHREADY  = '1;
        bus.slv_HREADY = 1'b1;
        bus.slv_HRESP  = 1'b0;
        bus.slv_HRDATA = 64'h0123_4567_89ab_cdef;
        step();
        HRESETn = 1'b1;

        // Reset state.
        @(negedge HCLK);
        check("rst_grant", granted_master, 5'b00001);
        check("rst_readyout", bus.mstHREADYOUT, 5'b11111);
        check("rst_resp", bus.mstHRESP, 5'b00000);

        // Equal-priority round-robin, lower priority stalled.
        do_reset();
        mstpriority[0] = 3'd1; mstpriority[1] = 3'd2; mstpriority[3] = 3'd2;
        for (int n = 0; n < 6; n++) begin
            drive(0, 2'b10, 3'd0, 1'b0);
            drive(1, 2'b10, 3'd0, 1'b0);
            drive(3, 2'b10, 3'd0, 1'b0);
            @(negedge HCLK);
            if (n == 1) check("rr_first_m1", granted_master, 5'b00010);
            if (n == 2) check("rr_then_m3", granted_master, 5'b01000);
            if (n == 2) check("rr_m0_stalled", bus.mstHREADYOUT[0], 1'b0);
            if (n == 3) check("rr_back_m1", granted_master, 5'b00010);
            step();
        end

        // INCR8 burst is not pre-empted by a higher priority request.
        do_reset();
        mstpriority[2] = 3'd3; mstpriority[4] = 3'd7;
        for (int n = 0; n < 12; n++) begin
            if (n <= 1)      drive(2, 2'b10, 3'd5, 1'b0);
            else if (n <= 8) drive(2, 2'b11, 3'd5, 1'b0);
            else             release_m(2);
            if (n >= 3) drive(4, 2'b10, 3'd0, 1'b0);
            @(negedge HCLK);
            if (n == 4)  check("burst_hold_mid", granted_master, 5'b00100);
            if (n == 4)  check("burst_m4_wait", bus.mstHREADYOUT[4], 1'b0);
            if (n == 8)  check("burst_hold_last", granted_master, 5'b00100);
            if (n == 9)  check("burst_hold_after", granted_master, 5'b00100);
            if (n == 10) check("burst_m4_granted", granted_master, 5'b10000);
            step();
        end

        // Locked master is never pre-empted, even by an aged higher-priority master.
        do_reset();
        mstpriority[1] = 3'd4;
        for (int n = 0; n < 23; n++) begin
            if (n < 20) drive(0, 2'b10, 3'd0, 1'b1);
            else        release_m(0);
            drive(1, 2'b10, 3'd0, 1'b0);
            @(negedge HCLK);
            if (n == 19) check("lock_hold", granted_master, 5'b00001);
            if (n == 19) check("lock_m1_wait", bus.mstHREADYOUT[1], 1'b0);
            if (n == 20) check("lock_drop_cycle", granted_master, 5'b00001);
            if (n == 21) check("lock_m1_granted", granted_master, 5'b00010);
            step();
        end

        // Starvation aging promotes a low-priority master.
        do_reset();
        mstpriority[1] = 3'd5; mstpriority[2] = 3'd5;
        for (int n = 0; n < 18; n++) begin
            drive(0, 2'b10, 3'd0, 1'b0);
            drive(1, 2'b10, 3'd0, 1'b0);
            drive(2, 2'b10, 3'd0, 1'b0);
            @(negedge HCLK);
            if (n == 13) check("age_before", granted_master, 5'b00010);
            if (n == 14) check("age_promoted", granted_master, 5'b00001);
            if (n == 15) check("age_still_top", granted_master, 5'b00001);
            if (n == 16) check("age_cleared", granted_master[0], 1'b0);
            step();
        end

        // SEQ shown by a newly granted master is presented as NONSEQ for one cycle.
        do_reset();
        mstpriority[3] = 3'd1;
        for (int n = 0; n < 4; n++) begin
            if (n < 3) drive(3, 2'b11, 3'd3, 1'b0);
            else       release_m(3);
            @(negedge HCLK);
            if (n == 0) check("fix_idle", bus.slv_HTRANS, 2'b00);
            if (n == 1) check("fix_grant", granted_master, 5'b01000);
            if (n == 1) check("fix_nonseq", bus.slv_HTRANS, 2'b10);
            if (n == 2) check("fix_seq", bus.slv_HTRANS, 2'b11);
            step();
        end

        // Reset in the middle of an INCR4 burst clears the beat count and the grant.
        do_reset();
        mstpriority[2] = 3'd2;
        for (int n = 0; n < 7; n++) begin
            if (n <= 1)      drive(2, 2'b10, 3'd3, 1'b0);
            else if (n <= 5) drive(2, 2'b11, 3'd3, 1'b0);
            else             release_m(2);
            HRESETn = (n == 3) ? 1'b0 : 1'b1;
            @(negedge HCLK);
            if (n == 2) check("midrst_owner", granted_master, 5'b00100);
            if (n == 4) check("midrst_grant0", granted_master, 5'b00001);
            if (n == 5) check("midrst_regrant", granted_master, 5'b00100);
            if (n == 5) check("midrst_fixup", bus.slv_HTRANS, 2'b10);
            step();
        end

        // Randomized traffic checked every cycle by the model.
        do_reset();
        for (int n = 0; n < 800; n++) begin
            for (int m = 0; m < M; m++) begin
                if ($urandom % 3 == 0) release_m(m);
                else drive(m, 2'($urandom), 3'($urandom), ($urandom % 12) == 0);
                if ($urandom % 20 == 0) mstpriority[m] = PB'($urandom);
            end
            bus.mstHREADY  = M'($urandom);
            bus.slv_HREADY = ($urandom % 4) != 0;
            bus.slv_HRESP  = ($urandom % 8) == 0;
            bus.slv_HRDATA = {$urandom, $urandom};
            HRESETn        = ($urandom % 150) != 0;
            step();
        end
        HRESETn = 1'b1;
        idle_all();
        step();
        @(negedge HCLK);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
